line_buffer_window_gen: RTL

LINE_BUFFER_WINDOW_GEN -- requirements
Module: line_buffer_window_gen

---
 rtl/line_buffer_window_gen_if.sv | 13 +
 rtl/line_buffer_window_gen.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/line_buffer_window_gen_if.sv
// Stream handshake bundle (data/valid/ready/last) shared by the pixel input
// and the window output of the line-buffer window generator.
interface line_buffer_window_gen_if #(
    parameter int unsigned WIDTH = 16
);
    logic [WIDTH-1:0] tdata;
    logic             tvalid;
    logic             tready;
    logic             tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/line_buffer_window_gen.sv
// 3x3 sliding-window generator over a square raster image with zero "same" padding,
// two line buffers, stride 1 or 2, and a single registered output stage.
module line_buffer_window_gen #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned MAX_WIDTH  = 128,
    parameter int unsigned CW         = $clog2(MAX_WIDTH) + 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [CW-1:0]            img_width,
    input  logic                     stride2,
    line_buffer_window_gen_if.slave  s_axis,
    line_buffer_window_gen_if.master m_axis,
    output logic                     frame_err
);
    localparam int unsigned AW = $clog2(MAX_WIDTH);

    typedef logic [DATA_WIDTH-1:0] pix_t;
    typedef logic [2:0][DATA_WIDTH-1:0] col_t;  // [0] is the top row

    typedef enum logic [1:0] {StIdle, StRun, StEdge, StFlush} state_t;
    state_t state_q, state_d;

    pix_t lb1_q [MAX_WIDTH];
    pix_t lb2_q [MAX_WIDTH];
    col_t c0_q, c1_q;

    logic [CW-1:0] row_q, col_q, fc_q, w_q;
    logic          s2_q, edge_top_q, edge_last_q, err_q;
    logic [9*DATA_WIDTH-1:0] m_data_q;
    logic          m_valid_q, m_last_q;

    logic [CW-1:0] w_eff, w_m1;
    logic          s2_eff, out_free, ready, accept, row_end, last_idx;
    logic [AW-1:0] rd_idx;
    col_t          new_col, win_l, win_m, win_r;
    logic          mask_top, mask_left, emit, emit_last, shift;
    logic [9*DATA_WIDTH-1:0] win;

    // Configuration is live while idle so the first pixel of a frame already uses it.
    assign w_eff    = (state_q == StIdle) ? img_width : w_q;
    assign s2_eff   = (state_q == StIdle) ? stride2 : s2_q;
    assign w_m1     = w_eff - CW'(1);
    assign out_free = !m_valid_q || m_axis.tready;
    assign ready    = !reset && (state_q == StIdle || state_q == StRun) && out_free;
    assign accept   = ready && s_axis.tvalid;
    assign row_end  = (col_q == w_m1);
    assign last_idx = row_end && (row_q == w_m1);
    assign rd_idx   = (state_q == StFlush) ? fc_q[AW-1:0] : col_q[AW-1:0];

    assign s_axis.tready = ready;
    assign m_axis.tdata  = m_data_q;
    assign m_axis.tvalid = m_valid_q;
    assign m_axis.tlast  = m_last_q;
    assign frame_err     = err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        new_col   = '0;
        mask_top  = 1'b0;
        mask_left = 1'b0;
        emit      = 1'b0;
        emit_last = 1'b0;
        shift     = 1'b0;
        unique case (state_q)
            StIdle, StRun: begin
                new_col   = {s_axis.tdata, lb1_q[rd_idx], lb2_q[rd_idx]};
                mask_top  = (row_q == CW'(1));
                mask_left = (col_q == CW'(1));
                if (accept) begin
                    shift     = 1'b1;
                    emit      = (row_q != '0) && (col_q != '0) &&
                                (!s2_eff || (row_q[0] && col_q[0]));
                    emit_last = s2_eff && last_idx;
                    if (last_idx) begin
                        state_d = s2_eff ? StIdle : StEdge;
                    end else if (!s2_eff && row_end && (row_q != '0)) begin
                        state_d = StEdge;
                    end else begin
                        state_d = StRun;
                    end
                end
            end
            StEdge: begin
                // Right-hand column is padding: the window slides off the image edge.
                mask_top = edge_top_q;
                if (out_free) begin
                    emit    = 1'b1;
                    state_d = edge_last_q ? StFlush : StRun;
                end
            end
            StFlush: begin
                if (fc_q != w_eff) begin
                    new_col = {pix_t'(0), lb1_q[rd_idx], lb2_q[rd_idx]};
                end
                mask_left = (fc_q == CW'(1));
                if (fc_q == '0) begin
                    shift = 1'b1;
                end else if (out_free) begin
                    shift     = 1'b1;
                    emit      = 1'b1;
                    emit_last = (fc_q == w_eff);
                    if (fc_q == w_eff) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        win_l = mask_left ? '0 : c0_q;
        win_m = c1_q;
        win_r = new_col;
        if (mask_top) begin
            win_l[0] = '0;
            win_m[0] = '0;
            win_r[0] = '0;
        end
        win = '0;
        for (int i = 0; i < 3; i++) begin
            win[DATA_WIDTH*(3*i)   +: DATA_WIDTH] = win_l[i];
            win[DATA_WIDTH*(3*i+1) +: DATA_WIDTH] = win_m[i];
            win[DATA_WIDTH*(3*i+2) +: DATA_WIDTH] = win_r[i];
        end
    end

    // Line buffers and column window carry no reset; stale rows are masked instead.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1_q[col_q[AW-1:0]] <= s_axis.tdata;
            lb2_q[col_q[AW-1:0]] <= lb1_q[col_q[AW-1:0]];
        end
        if (shift) begin
            c0_q <= c1_q;
            c1_q <= new_col;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            row_q       <= '0;
            col_q       <= '0;
            fc_q        <= '0;
            w_q         <= img_width;
            s2_q        <= stride2;
            edge_top_q  <= 1'b0;
            edge_last_q <= 1'b0;
            err_q       <= 1'b0;
            m_data_q    <= '0;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
        end else begin
            if (state_q == StIdle) begin
                w_q  <= img_width;
                s2_q <= stride2;
            end
            if (accept) begin
                edge_top_q  <= (row_q == CW'(1));
                edge_last_q <= last_idx;
                if (s_axis.tlast != last_idx) begin
                    err_q <= 1'b1;
                end
                if (last_idx) begin
                    row_q <= '0;
                    col_q <= '0;
                end else if (row_end) begin
                    row_q <= row_q + CW'(1);
                    col_q <= '0;
                end else begin
                    col_q <= col_q + CW'(1);
                end
            end
            if (state_q == StFlush && shift) begin
                fc_q <= (fc_q == w_eff) ? '0 : fc_q + CW'(1);
            end
            if (emit) begin
                m_data_q  <= win;
                m_valid_q <= 1'b1;
                m_last_q  <= emit_last;
            end else if (m_axis.tready) begin
                m_valid_q <= 1'b0;
                m_last_q  <= 1'b0;
            end
        end
    end
endmodule
